ysyx_24110006_ifu: RTL and testbench
====================================

Name: ysyx_24110006_ifu

Overview:
- Instruction fetch unit for the multi-cycle core. It owns the architectural PC and fetches one instruction at a time over a valid/ready instruction-memory bus.
- It presents each fetched instruction with its PC to the decode stage.
- It waits for retirement and takes the next PC from the execute unit's jump/target outputs (jump flag, 32-bit target). It is the producer and PC-consumer end of the execute interface.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- TIMEOUT, 255, max cycles waiting for a memory response before a fetch fault; TIMEOUT >= 1.
- CNT_W, 8, width of the response-timeout counter; must hold TIMEOUT.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- o_imem_req_valid  out  1  fetch request valid.
- i_imem_req_ready  in  1  memory accepts request.
- o_imem_addr  out  32  fetch address, equals PC.
- i_imem_rsp_valid  in  1  response valid, single-cycle pulse.
- i_imem_rdata  in  32  instruction word.
- i_imem_rsp_err  in  1  bus error qualifying rsp_valid.
- o_inst_valid  out  1  instruction available to decode.
- i_inst_ready  in  1  decode accepts instruction.
- o_inst  out  32  instruction word.
- o_pc  out  32  PC of o_inst.
- o_fault  out  1  fetch fault: bus error, timeout, or misaligned target; sticky until reset.
- i_wb_valid  in  1  current instruction retired this cycle.
- i_jump  in  1  retired instruction redirects, from execute jump output.
- i_upc  in  32  redirect target, from execute target output.
- o_retired  out  32  count of retired instructions, wraps.

Behaviour:
- Reset, async on i_rst_n low:
  - State IDLE; pc=RESET_PC; o_inst=0; o_fault=0; o_retired=0; timeout counter=0.
  - All valid outputs are 0.
- States:
  - IDLE: next clock goes to REQ.
  - REQ: o_imem_req_valid=1, o_imem_addr=pc. If i_imem_req_ready is high, go to WAIT_RSP and clear the counter. Otherwise hold, with addr stable.
  - WAIT_RSP:
    - Counter increments each cycle.
    - On i_imem_rsp_valid with rsp_err=0: latch rdata into o_inst and go to HOLD.
    - On rsp_valid with rsp_err=1: set o_fault and go to HALT.
    - If the counter reaches TIMEOUT with no rsp_valid: set o_fault and go to HALT.
    - rsp_valid and timeout in the same cycle: the response wins.
  - HOLD: o_inst_valid=1; o_inst and o_pc stable. On i_inst_ready, go to WAIT_WB.
  - WAIT_WB:
    - On i_wb_valid: o_retired+=1, and next pc = i_jump ? {i_upc[31:1],1'b0} : pc+4, mod 2^32.
    - If i_jump and i_upc[1]=1: set o_fault and go to HALT. The count still increments; pc is not updated.
    - Otherwise go to REQ.
  - HALT: terminal. No requests, no valids, outputs frozen until reset.
- Minimum latency per instruction: 1 request cycle, at least 1 response cycle, 1 hold cycle, at least 1 retire cycle. There is no overlap; one instruction is in flight at a time.
- Inputs outside their state are ignored:
  - rsp_valid outside WAIT_RSP.
  - inst_ready outside HOLD.
  - wb_valid outside WAIT_WB.
- A response in the same cycle as request acceptance is not sampled. Memory must respond no earlier than the following cycle.
- pc+4 wraps 32'hFFFF_FFFC to 32'h0000_0000.
- Reset asserted mid-transaction aborts it immediately. A late response after reset is ignored, since the state is not WAIT_RSP.
- o_pc always equals the registered pc. It changes only on retirement.

Test Plan:
- Reset release, memory always ready, rsp 1 cycle later with 32'h00000013, inst_ready=1, wb_valid one cycle later with i_jump=0 -> addr 8000_0000, then 8000_0004; o_retired=1; o_pc=8000_0000 while o_inst_valid is high.
- Retire with i_jump=1, i_upc=32'h8000_0101 -> next o_imem_addr=8000_0100, no fault. Then i_upc=32'h8000_0102 -> o_fault=1, HALT, o_imem_req_valid stays 0.
- i_imem_req_ready low for 5 cycles -> req_valid and addr held stable for all 5; exactly one transfer on acceptance.
- No response for TIMEOUT=3 cycles -> o_fault=1 on the 3rd WAIT_RSP cycle. Repeat with rsp_valid on that same cycle -> no fault, instruction latched.
- rsp_err=1 -> o_fault=1, o_inst_valid never asserts. Spurious rsp_valid and wb_valid in HOLD -> no state change.
- Reset pulse while in WAIT_RSP, then a response arrives -> response ignored, pc=RESET_PC, fresh request issued after IDLE.

Source files
------------

// File: rtl/ysyx_24110006_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24110006_ifu
// Purpose  : Multi-cycle instruction fetch unit. It owns the PC, fetches one
//            instruction at a time and waits for retirement before redirecting.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_24110006_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_rsp_err,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_fault,
    input  logic        i_wb_valid,
    input  logic        i_jump,
    input  logic [31:0] i_upc,
    output logic [31:0] o_retired
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT_RSP = 3'd2,
        S_HOLD     = 3'd3,
        S_WAIT_WB  = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      inst_q;
    logic [31:0]      retired_q;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      pc_d;
    logic             w_misaligned;

    // Bit 0 of the target is always dropped; bit 1 set means a misaligned target.
    assign pc_d         = i_jump ? (i_upc & ~32'd1) : (pc_q + 32'd4);
    assign w_misaligned = i_jump & i_upc[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    if (i_imem_req_ready) begin
                        state_q <= S_WAIT_RSP;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT_RSP: begin
                    cnt_q <= cnt_q + C_CNT_ONE;
                    // A response on the final counted cycle beats the timeout.
                    if (i_imem_rsp_valid) begin
                        if (i_imem_rsp_err) begin
                            fault_q <= 1'b1;
                            state_q <= S_HALT;
                        end else begin
                            inst_q  <= i_imem_rdata;
                            state_q <= S_HOLD;
                        end
                    end else if (cnt_q == C_CNT_LAST) begin
                        fault_q <= 1'b1;
                        state_q <= S_HALT;
                    end
                end
                S_HOLD: begin
                    if (i_inst_ready) begin
                        state_q <= S_WAIT_WB;
                    end
                end
                S_WAIT_WB: begin
                    if (i_wb_valid) begin
                        retired_q <= retired_q + 32'd1;
                        if (w_misaligned) begin
                            fault_q <= 1'b1;
                            state_q <= S_HALT;
                        end else begin
                            pc_q    <= pc_d;
                            state_q <= S_REQ;
                        end
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign o_imem_req_valid = (state_q == S_REQ);
    assign o_imem_addr      = pc_q;
    assign o_inst_valid     = (state_q == S_HOLD);
    assign o_inst           = inst_q;
    assign o_pc             = pc_q;
    assign o_fault          = fault_q;
    assign o_retired        = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24110006_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24110006_ifu
// Purpose  : Self-checking bench for the fetch unit: directed corner cases plus
//            randomized transactions against a transaction-level PC model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_24110006_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TO     = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid, req_ready;
    logic [31:0] addr;
    logic        rsp_valid, rsp_err;
    logic [31:0] rdata;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, pc;
    logic        fault;
    logic        wb_valid, jump;
    logic [31:0] upc, retired;

    int          n_checks = 0;
    int          n_pass   = 0;

    // Architectural model: what the PC, retire count and fault flag must be.
    logic [31:0] m_pc, m_ret;
    logic        m_fault;

    ysyx_24110006_ifu #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TO),
        .CNT_W    (8)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_addr      (addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rdata     (rdata),
        .i_imem_rsp_err   (rsp_err),
        .o_inst_valid     (inst_valid),
        .i_inst_ready     (inst_ready),
        .o_inst           (inst),
        .o_pc             (pc),
        .o_fault          (fault),
        .i_wb_valid       (wb_valid),
        .i_jump           (jump),
        .i_upc            (upc),
        .o_retired        (retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        rdata      = 32'h0;
        inst_ready = 1'b0;
        wb_valid   = 1'b0;
        jump       = 1'b0;
        upc        = 32'h0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check_eq("rst_pc",      pc,                 RST_PC);
        check_eq("rst_inst",    inst,               32'h0);
        check_eq("rst_retired", retired,            32'h0);
        check_eq("rst_flags",   {28'h0, req_valid, inst_valid, fault, 1'b0}, 32'h0);
        step();
        step();
        rst_n   = 1'b1;
        m_pc    = RST_PC;
        m_ret   = 32'h0;
        m_fault = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (req_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        ok = (req_valid === 1'b1);
        if (!ok) check_eq("req_wait", {31'h0, req_valid}, 32'h1);
    endtask

    task automatic accept_req(input bit junk_rsp);
        req_ready = 1'b1;
        if (junk_rsp) begin
            rsp_valid = 1'b1;
            rdata     = 32'hBAD0_0BAD;
        end
        step();
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        check_eq("req_drop", {31'h0, req_valid}, 32'h0);
    endtask

    task automatic fetch_one(input logic [31:0] word, input int req_dly, input int rsp_dly,
                             input int hold_dly, input int wb_dly, input bit j,
                             input logic [31:0] tgt, input bit spur);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        check_eq("req_addr", addr, m_pc);
        check_eq("req_pc",   pc,   m_pc);
        for (int i = 0; i < req_dly; i++) begin
            step();
            check_eq("stall_v",    {31'h0, req_valid}, 32'h1);
            check_eq("stall_addr", addr,               m_pc);
        end
        accept_req(spur);
        for (int i = 0; i < rsp_dly; i++) step();
        rsp_valid = 1'b1;
        rdata     = word;
        step();
        rsp_valid = 1'b0;
        rdata     = $urandom;
        check_eq("hold_v",     {31'h0, inst_valid}, 32'h1);
        check_eq("hold_inst",  inst,                word);
        check_eq("hold_pc",    pc,                  m_pc);
        check_eq("hold_fault", {31'h0, fault},      32'h0);
        for (int i = 0; i < hold_dly; i++) begin
            if (spur) begin
                rsp_valid = 1'b1;
                wb_valid  = 1'b1;
                jump      = 1'b1;
                upc       = $urandom;
            end
            step();
            clear_inputs();
            check_eq("spur_v",    {31'h0, inst_valid}, 32'h1);
            check_eq("spur_inst", inst,                word);
            check_eq("spur_ret",  retired,             m_ret);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check_eq("wb_vdrop", {31'h0, inst_valid}, 32'h0);
        for (int i = 0; i < wb_dly; i++) begin
            step();
            check_eq("wb_wait_pc", pc, m_pc);
        end
        wb_valid = 1'b1;
        jump     = j;
        upc      = tgt;
        step();
        clear_inputs();
        m_ret = m_ret + 32'd1;
        if (j && tgt[1]) m_fault = 1'b1;
        else if (j)      m_pc = {tgt[31:1], 1'b0};
        else             m_pc = m_pc + 32'd4;
        check_eq("retired", retired,        m_ret);
        check_eq("fault",   {31'h0, fault}, {31'h0, m_fault});
        check_eq("next_pc", pc,             m_pc);
        if (m_fault) begin
            for (int i = 0; i < 4; i++) begin
                step();
                check_eq("halt_req", {31'h0, req_valid, inst_valid}, 32'h0);
            end
        end
    endtask

    initial begin
        bit ok;
        clear_inputs();
        #1;
        apply_reset();

        // Basic fetch, then redirects: aligned-odd target and misaligned target.
        fetch_one(32'h0000_0013, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0);
        fetch_one(32'h1111_1111, 0, 0, 0, 0, 1'b1, 32'h8000_0101, 1'b0);
        fetch_one(32'h2222_2222, 0, 1, 0, 1, 1'b1, 32'h8000_0102, 1'b0);

        // Request stall, then PC wrap around the top of the address space.
        apply_reset();
        fetch_one(32'h3333_3333, 5, 0, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        fetch_one(32'h4444_4444, 0, TO - 1, 1, 0, 1'b0, 32'h0, 1'b1);
        check_eq("wrap_pc", pc, 32'h0);

        for (int n = 0; n < 40; n++) begin
            fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, TO - 1),
                      $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      $urandom & ~32'h2, 1'($urandom_range(0, 1)));
        end
        fetch_one($urandom, 0, 0, 0, 0, 1'b1, $urandom | 32'h2, 1'b0);

        // Response timeout, followed by a late response that must be ignored.
        apply_reset();
        wait_req(ok);
        accept_req(1'b0);
        step();
        step();
        check_eq("to_early", {31'h0, fault}, 32'h0);
        step();
        check_eq("to_fault", {31'h0, fault},            32'h1);
        check_eq("to_halt",  {31'h0, req_valid, inst_valid}, 32'h0);
        rsp_valid = 1'b1;
        rdata     = 32'hDEAD_BEEF;
        step();
        rsp_valid = 1'b0;
        check_eq("to_late", {31'h0, inst_valid}, 32'h0);
        check_eq("to_inst", inst,                32'h0);

        // Bus error response.
        apply_reset();
        wait_req(ok);
        accept_req(1'b0);
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        rdata     = 32'hCAFE_F00D;
        step();
        clear_inputs();
        check_eq("err_fault", {31'h0, fault}, 32'h1);
        check_eq("err_inst",  inst,           32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("err_halt", {31'h0, req_valid, inst_valid}, 32'h0);
        end

        // Reset in WAIT_RSP aborts the fetch; the stray response is dropped.
        apply_reset();
        fetch_one(32'h5555_5555, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0);
        wait_req(ok);
        accept_req(1'b0);
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_pc", pc, RST_PC);
        check_eq("mid_rst_ret", retired, 32'h0);
        rst_n     = 1'b1;
        rsp_valid = 1'b1;
        rdata     = 32'hDEAD_0001;
        step();
        rsp_valid = 1'b0;
        m_pc    = RST_PC;
        m_ret   = 32'h0;
        m_fault = 1'b0;
        check_eq("mid_rst_inst", inst, 32'h0);
        fetch_one(32'h6666_6666, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
